traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Sequencing controller for a two-road (north-south / east-west) intersection. It consumes the 1 Hz single-cycle tick from the one-second pulse generator and steps a phase state machine with per-phase durations. It latches pedestrian requests and serves them in an all-red walk phase. It drives the lamp outputs and a seconds-remaining count for the countdown display.

## Interface
- GREEN_S, default 25: green phase length in ticks, legal range 1..2^CNT_W-1.
- YELLOW_S, default 3: yellow phase length in ticks, legal range 1..2^CNT_W-1.
- ALLRED_S, default 2: all-red clearance length in ticks, legal range 1..2^CNT_W-1.
- PED_S, default 10: pedestrian walk length in ticks, legal range 1..2^CNT_W-1.
- CNT_W, default 6: width of the remaining-time counter.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-high.
- tick  in  1  one-cycle pulse, once per second, from the pulse generator.
- ped_req  in  1  pedestrian button; any cycle high registers a request.
- ns_light  out  3  north-south lamps {red,yellow,green}, one-hot.
- ew_light  out  3  east-west lamps {red,yellow,green}, one-hot.
- ped_walk  out  1  walk signal; high only in PED_WALK.
- ped_pending  out  1  a request is latched and not yet served.
- remaining  out  CNT_W  ticks left in the current phase, for display.
- phase  out  3  current state encoding, for debug.

## Operation
- States and their lamps:
  - ALLRED_A: NS red, EW red.
  - NS_GREEN: NS green, EW red.
  - NS_YELLOW: NS yellow, EW red.
  - ALLRED_B: NS red, EW red.
  - EW_GREEN: NS red, EW green.
  - EW_YELLOW: NS red, EW yellow.
  - PED_WALK: both roads red, ped_walk=1.
- Phase encodings: ALLRED_A=0, NS_GREEN=1, NS_YELLOW=2, ALLRED_B=3, EW_GREEN=4, EW_YELLOW=5, PED_WALK=6.
- Normal cycle: ALLRED_A -> NS_GREEN -> NS_YELLOW -> ALLRED_B -> EW_GREEN -> EW_YELLOW -> ALLRED_A.
- Pedestrian detour:
  - On exit from ALLRED_A or ALLRED_B with ped_pending=1, go to PED_WALK instead of the next green.
  - A 1-bit return register records the origin.
  - PED_WALK exits to NS_GREEN if entered from ALLRED_A, else to EW_GREEN.
- Phase length: on entry to a phase, remaining loads that phase's parameter. Each tick decrements remaining by 1.
- Transition condition: the clock edge where tick=1 and remaining==1. On that edge the state advances and remaining loads the next phase's length. Each phase therefore lasts exactly its parameter in ticks.
- remaining never reaches 0 in operation.
- ped_pending register:
  - Set on any cycle where ped_req=1 and state is not PED_WALK.
  - Cleared on the edge that enters PED_WALK. Clear wins over a simultaneous set.
  - ped_req is ignored while in PED_WALK.
  - Multiple presses before service count as one request.
- Safety invariant: never green/yellow on both roads in the same cycle. In PED_WALK, both roads are red.
- Width rule: parameters are truncated to CNT_W bits. A zero-length parameter is illegal and is not checked in RTL.

## Timing
- Reset (rst=1 at an edge):
  - state=ALLRED_A, remaining=ALLRED_S.
  - ns_light=ew_light=3'b100.
  - ped_walk=0, ped_pending=0, return register=A.
  - tick and ped_req are ignored during reset.
- Reset mid-phase takes effect on the next edge regardless of tick. There is no yellow run-out.
- All outputs are registered and change only on the edge that changes state or remaining. No combinational path from inputs to outputs.
- Lamp change latency: the tick that ends a phase changes the lamps on that same clock edge, visible the following cycle.
- ped_req to ped_pending: 1 clock.
- Walk service latency: at most one full cycle plus ALLRED time. A request is served at the next ALLRED exit after it is latched.
- A tick with remaining>1 only decrements remaining; state and lamps hold.
- Cycles with tick=0 change nothing except ped_pending.
- tick high for more than one clock counts once per high clock. The upstream generator guarantees one-cycle pulses.

## Test plan
All scenarios use GREEN_S=4, YELLOW_S=2, ALLRED_S=1, PED_S=3, CNT_W=6, with tick every 5 clocks.
- Reset then free-run without ped_req:
  - Phases must follow 0,1,2,3,4,5,0 with lengths 1,4,2,1,4,2 ticks.
  - remaining reads 4,3,2,1 during NS_GREEN.
  - ns_light/ew_light must match the state list every cycle.
- Pulse ped_req during NS_GREEN:
  - ped_pending rises 1 clock later.
  - After ALLRED_B expires: PED_WALK for 3 ticks with ped_walk=1 and both lamps 100.
  - Then EW_GREEN, with ped_pending=0.
- ped_req during EW_YELLOW: PED_WALK is entered from ALLRED_A and returns to NS_GREEN.
- ped_req held high throughout PED_WALK and released on its last cycle: no second walk occurs; ped_pending stays 0 on exit.
- Assert rst mid-NS_GREEN with remaining=2 and tick coincident: the next cycle shows state ALLRED_A, remaining=1, both lamps red, ped_pending=0.
- Random tick/ped_req over 10k cycles with an assertion: never (NS not red and EW not red), and ped_walk=1 implies both lamps red.

Source files
------------

// File: rtl/traffic_light_ctrl_if.sv
// Signal bundle between the intersection controller and its environment:
// the 1 Hz tick and pedestrian button in, lamp/walk/countdown status out.
interface traffic_light_ctrl_if #(
    parameter int CNT_W = 6
);
    logic             tick;
    logic             ped_req;
    logic [2:0]       ns_light;
    logic [2:0]       ew_light;
    logic             ped_walk;
    logic             ped_pending;
    logic [CNT_W-1:0] remaining;
    logic [2:0]       phase;

    modport master (
        output tick,
        output ped_req,
        input  ns_light,
        input  ew_light,
        input  ped_walk,
        input  ped_pending,
        input  remaining,
        input  phase
    );

    modport slave (
        input  tick,
        input  ped_req,
        output ns_light,
        output ew_light,
        output ped_walk,
        output ped_pending,
        output remaining,
        output phase
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road intersection sequencer: steps lamp phases on the 1 Hz tick, with an
// all-red pedestrian walk phase inserted at the next all-red exit after a request.
module traffic_light_ctrl #(
    parameter int GREEN_S  = 25,
    parameter int YELLOW_S = 3,
    parameter int ALLRED_S = 2,
    parameter int PED_S    = 10,
    parameter int CNT_W    = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    traffic_light_ctrl_if.slave   bus
);

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        PED_WALK  = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] GREEN_LEN  = CNT_W'(GREEN_S);
    localparam logic [CNT_W-1:0] YELLOW_LEN = CNT_W'(YELLOW_S);
    localparam logic [CNT_W-1:0] ALLRED_LEN = CNT_W'(ALLRED_S);
    localparam logic [CNT_W-1:0] PED_LEN    = CNT_W'(PED_S);
    localparam logic [CNT_W-1:0] ONE        = CNT_W'(1);

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] remaining_nxt;
    logic             ret_ew;
    logic             ret_ew_nxt;
    logic             pending;
    logic             pending_nxt;
    logic [2:0]       ns_lamp;
    logic [2:0]       ew_lamp;
    logic             walk;

    function automatic logic [CNT_W-1:0] phase_len(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   phase_len = GREEN_LEN;
            NS_YELLOW, EW_YELLOW: phase_len = YELLOW_LEN;
            PED_WALK:             phase_len = PED_LEN;
            default:              phase_len = ALLRED_LEN;
        endcase
    endfunction

    function automatic logic [2:0] ns_lamp_of(input state_t s);
        case (s)
            NS_GREEN:  ns_lamp_of = LAMP_GRN;
            NS_YELLOW: ns_lamp_of = LAMP_YEL;
            default:   ns_lamp_of = LAMP_RED;
        endcase
    endfunction

    function automatic logic [2:0] ew_lamp_of(input state_t s);
        case (s)
            EW_GREEN:  ew_lamp_of = LAMP_GRN;
            EW_YELLOW: ew_lamp_of = LAMP_YEL;
            default:   ew_lamp_of = LAMP_RED;
        endcase
    endfunction

    always_comb begin
        state_nxt     = state;
        remaining_nxt = remaining;
        ret_ew_nxt    = ret_ew;
        pending_nxt   = pending | (bus.ped_req && (state != PED_WALK));

        if (bus.tick) begin
            if (remaining == ONE) begin
                case (state)
                    ALLRED_A: begin
                        if (pending) begin
                            state_nxt  = PED_WALK;
                            ret_ew_nxt = 1'b0;
                        end else begin
                            state_nxt  = NS_GREEN;
                        end
                    end
                    NS_GREEN:  state_nxt = NS_YELLOW;
                    NS_YELLOW: state_nxt = ALLRED_B;
                    ALLRED_B: begin
                        if (pending) begin
                            state_nxt  = PED_WALK;
                            ret_ew_nxt = 1'b1;
                        end else begin
                            state_nxt  = EW_GREEN;
                        end
                    end
                    EW_GREEN:  state_nxt = EW_YELLOW;
                    EW_YELLOW: state_nxt = ALLRED_A;
                    PED_WALK:  state_nxt = ret_ew ? EW_GREEN : NS_GREEN;
                    default:   state_nxt = ALLRED_A;
                endcase
                remaining_nxt = phase_len(state_nxt);
            end else begin
                remaining_nxt = remaining - ONE;
            end
        end

        // Entering the walk serves the request; this beats a same-cycle press.
        if ((state_nxt == PED_WALK) && (state != PED_WALK)) begin
            pending_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ALLRED_A;
            remaining <= ALLRED_LEN;
            ret_ew    <= 1'b0;
            pending   <= 1'b0;
            ns_lamp   <= LAMP_RED;
            ew_lamp   <= LAMP_RED;
            walk      <= 1'b0;
        end else begin
            state     <= state_nxt;
            remaining <= remaining_nxt;
            ret_ew    <= ret_ew_nxt;
            pending   <= pending_nxt;
            ns_lamp   <= ns_lamp_of(state_nxt);
            ew_lamp   <= ew_lamp_of(state_nxt);
            walk      <= (state_nxt == PED_WALK);
        end
    end

    assign bus.ns_light    = ns_lamp;
    assign bus.ew_light    = ew_lamp;
    assign bus.ped_walk    = walk;
    assign bus.ped_pending = pending;
    assign bus.remaining   = remaining;
    assign bus.phase       = state;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Scoreboard bench for traffic_light_ctrl: directed scenarios plus random
// tick/ped_req traffic, checked against a phase/elapsed-time reference model.
module tb_traffic_light_ctrl;

    localparam int GREEN_S  = 4;
    localparam int YELLOW_S = 2;
    localparam int ALLRED_S = 1;
    localparam int PED_S    = 3;
    localparam int CNT_W    = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;

    traffic_light_ctrl_if #(.CNT_W(CNT_W)) bus ();

    traffic_light_ctrl #(
        .GREEN_S (GREEN_S),
        .YELLOW_S(YELLOW_S),
        .ALLRED_S(ALLRED_S),
        .PED_S   (PED_S),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]       ns;
        logic [2:0]       ew;
        logic             walk;
        logic             pend;
        logic [CNT_W-1:0] rem;
        logic [2:0]       ph;
    } exp_t;

    exp_t sb[$];
    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model: phase number, ticks elapsed in it, latched request, walk origin.
    int dur[7] = '{ALLRED_S, GREEN_S, YELLOW_S, ALLRED_S, GREEN_S, YELLOW_S, PED_S};
    int m_ph   = 0;
    int m_el   = 0;
    bit m_pend = 0;
    bit m_from_a = 1;

    function automatic int next_phase(input int p, input bit pend, input bit from_a);
        if (p == 6) return from_a ? 1 : 4;
        if ((p == 0 || p == 3) && pend) return 6;
        return (p + 1) % 6;
    endfunction

    task automatic model_update(input bit r, input bit t, input bit q);
        bit new_pend;
        int np;
        if (r) begin
            m_ph = 0; m_el = 0; m_pend = 0; m_from_a = 1;
            return;
        end
        new_pend = m_pend | (q && m_ph != 6);
        if (t) begin
            m_el++;
            if (m_el == dur[m_ph]) begin
                np = next_phase(m_ph, m_pend, m_from_a);
                if (np == 6) begin
                    m_from_a = (m_ph == 0);
                    new_pend = 0;
                end
                m_ph = np;
                m_el = 0;
            end
        end
        m_pend = new_pend;
    endtask

    function automatic exp_t model_out();
        exp_t e;
        e.ns   = (m_ph == 1) ? 3'b001 : (m_ph == 2) ? 3'b010 : 3'b100;
        e.ew   = (m_ph == 4) ? 3'b001 : (m_ph == 5) ? 3'b010 : 3'b100;
        e.walk = (m_ph == 6);
        e.pend = m_pend;
        e.rem  = CNT_W'(dur[m_ph] - m_el);
        e.ph   = 3'(m_ph);
        return e;
    endfunction

    task automatic step(input bit r, input bit t, input bit q);
        rst = r;
        bus.tick = t;
        bus.ped_req = q;
        @(posedge clk);
        model_update(r, t, q);
        sb.push_back(model_out());
        #1;
    endtask

    task automatic cyc_step(input bit r, input bit q);
        bit t;
        t = (cyc % 5 == 4);
        cyc++;
        step(r, t, q);
    endtask

    // Advance with tick every 5 clocks until the model reaches the target
    // phase (and remaining, if nonzero; and a tick due next, if asked).
    task automatic wait_for(input int ph, input int rem, input bit need_tick, input string name);
        int n;
        n = 0;
        while (!(m_ph == ph && (rem == 0 || dur[m_ph] - m_el == rem) &&
                 (!need_tick || cyc % 5 == 4))) begin
            if (n == 500) begin
                checks++;
                failures++;
                $display("FAIL wait_%s got_phase=%0d want_phase=%0d (budget expired)", name, m_ph, ph);
                return;
            end
            cyc_step(0, 0);
            n++;
        end
    endtask

    task automatic check_field(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check_field("phase",       int'(bus.phase),       int'(e.ph));
            check_field("remaining",   int'(bus.remaining),   int'(e.rem));
            check_field("ns_light",    int'(bus.ns_light),    int'(e.ns));
            check_field("ew_light",    int'(bus.ew_light),    int'(e.ew));
            check_field("ped_walk",    int'(bus.ped_walk),    int'(e.walk));
            check_field("ped_pending", int'(bus.ped_pending), int'(e.pend));
            checks++;
            if ((bus.ns_light != 3'b100 && bus.ew_light != 3'b100) ||
                (bus.ped_walk && (bus.ns_light != 3'b100 || bus.ew_light != 3'b100))) begin
                failures++;
                $display("FAIL safety ns=%b ew=%b walk=%b t=%0t", bus.ns_light, bus.ew_light,
                         bus.ped_walk, $time);
            end
        end
    end

    initial begin
        bus.tick = 1'b0;
        bus.ped_req = 1'b0;

        // Reset, then one full free-running cycle and a bit more.
        cyc_step(1, 0);
        cyc_step(1, 0);
        repeat (80) cyc_step(0, 0);

        // Request during NS_GREEN: walk after ALLRED_B, return to EW_GREEN.
        wait_for(1, 3, 0, "ns_green");
        cyc_step(0, 1);
        repeat (100) cyc_step(0, 0);

        // Request during EW_YELLOW: walk after ALLRED_A, return to NS_GREEN.
        wait_for(5, 0, 0, "ew_yellow");
        cyc_step(0, 1);
        repeat (100) cyc_step(0, 0);

        // Button held through the whole walk, released on its last cycle.
        wait_for(1, 0, 0, "ns_green2");
        cyc_step(0, 1);
        wait_for(6, 0, 0, "walk");
        for (int n = 0; n < 100 && m_ph == 6; n++) begin
            bit t;
            t = (cyc % 5 == 4);
            cyc++;
            step(0, t, !(t && (m_el + 1 == dur[6])));
        end
        repeat (100) cyc_step(0, 0);

        // Reset coincident with a tick, mid-NS_GREEN at remaining=2.
        wait_for(1, 2, 1, "ns_green_rem2");
        cyc_step(1, 0);
        repeat (20) cyc_step(0, 0);

        // Random tick / button traffic.
        for (int i = 0; i < 10000; i++) begin
            step(($urandom % 4000) == 0, ($urandom % 5) == 0, ($urandom % 23) == 0);
        end

        repeat (2) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
